box_plotter: RTL and testbench



---
 rtl/box_plotter_if.sv | 29 ++
 rtl/box_plotter.sv | 143 ++++++++++++++
 tb/tb_box_plotter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/box_plotter_if.sv
// Box request / pixel stream bundle between the box-coordinate logic,
// the box_plotter and the vga_adapter plot port.
interface box_plotter_if #(
   parameter int SIZE_W = 4
);
   logic              start;
   logic [7:0]        givex;
   logic [6:0]        givey;
   logic [SIZE_W-1:0] size;
   logic [2:0]        colour;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [2:0]        colour_out;
   logic              plot;
   logic              busy;
   logic              done;

   // Requester side: issues boxes, watches the pixel stream.
   modport master (
      output start, givex, givey, size, colour,
      input  x, y, colour_out, plot, busy, done
   );

   // Plotter side: accepts boxes, emits one pixel per clock.
   modport slave (
      input  start, givex, givey, size, colour,
      output x, y, colour_out, plot, busy, done
   );
endinterface

// File: rtl/box_plotter.sv
// box_plotter: walks every pixel of a filled square in row-major order,
// one pixel per clock, then pulses done for one cycle.
// Optional feature macro: BOX_CLIP_EN -- when defined, pixels falling
// outside SCREEN_W x SCREEN_H keep their cycle but have plot suppressed.
module box_plotter #(
   parameter int SIZE_W   = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic         clock,
   input  logic         reset,
   box_plotter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   // Latched request: origin, side and colour of the box being drawn.
   logic [7:0]        bx;
   logic [6:0]        by;
   logic [SIZE_W-1:0] bs;
   logic [2:0]        bc;

   // Column / row position inside the box.
   logic [SIZE_W-1:0] cx;
   logic [SIZE_W-1:0] cy;

   logic              last_col;
   logic              last_row;
   logic              drawing;

   assign last_col = (cx == bs - 1'b1);
   assign last_row = (cy == bs - 1'b1);

`ifdef BOX_CLIP_EN
   // Wide sums so that pixels past the right/bottom screen edge are seen
   // as off-screen instead of wrapping back onto the visible area.
   localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
   localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

   logic [8:0] xsum;
   logic [7:0] ysum;

   assign xsum     = {1'b0, bx} + 9'(cx);
   assign ysum     = {1'b0, by} + 8'(cy);
   assign bus.x    = xsum[7:0];
   assign bus.y    = ysum[6:0];
   assign bus.plot = drawing && (xsum < SCR_W9) && (ysum < SCR_H8);
`else
   // Without clipping the coordinates simply wrap at 256 / 128.
   logic [7:0] xsum;
   logic [6:0] ysum;

   assign xsum     = bx + 8'(cx);
   assign ysum     = by + 7'(cy);
   assign bus.x    = xsum;
   assign bus.y    = ysum;
   assign bus.plot = drawing;
`endif

   assign bus.colour_out = bc;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and status decode; outputs depend on registered state only.
   always_comb begin
      state_d  = state_q;
      drawing  = 1'b0;
      bus.busy = 1'b1;
      bus.done = 1'b0;
      case (state_q)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               state_d = (bus.size == '0) ? DONE : DRAW;
            end
         end
         DRAW: begin
            drawing = 1'b1;
            if (last_col && last_row) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request latch and row-major pixel counters; counters freeze on the
   // last pixel so x/y keep showing it after the box completes.
   always_ff @(posedge clock) begin
      if (reset) begin
         bx <= '0;
         by <= '0;
         bs <= '0;
         bc <= '0;
         cx <= '0;
         cy <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bx <= bus.givex;
                  by <= bus.givey;
                  bs <= bus.size;
                  bc <= bus.colour;
                  cx <= '0;
                  cy <= '0;
               end
            end
            DRAW: begin
               if (!last_col) begin
                  cx <= cx + 1'b1;
               end else if (!last_row) begin
                  cx <= '0;
                  cy <= cy + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_box_plotter.sv
// Randomised self-checking bench for box_plotter. The reference model
// builds the expected pixel list of each box directly from its geometry.
module tb_box_plotter;
   localparam int SIZE_W   = 4;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   logic clock = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   box_plotter_if #(.SIZE_W(SIZE_W)) bus ();

   box_plotter #(
      .SIZE_W  (SIZE_W),
      .SCREEN_W(SCREEN_W),
      .SCREEN_H(SCREEN_H)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int exp_plot(input int px, input int py);
`ifdef BOX_CLIP_EN
      return ((px < SCREEN_W) && (py < SCREEN_H)) ? 1 : 0;
`else
      return 1;
`endif
   endfunction

   task automatic scramble_inputs();
      bus.start  = 1'($urandom_range(0, 1));
      bus.givex  = 8'($urandom);
      bus.givey  = 7'($urandom);
      bus.size   = SIZE_W'($urandom);
      bus.colour = 3'($urandom);
   endtask

   // Called at a negedge while the DUT is idle; returns at the negedge of
   // the idle cycle following DONE, so a further call is back-to-back.
   task automatic run_box(input int gx, input int gy, input int n, input int c,
                          input bit scramble);
      int ex[$];
      int ey[$];
      int ep[$];
      int hx;
      int hy;
      for (int r = 0; r < n; r++) begin
         for (int col = 0; col < n; col++) begin
            ex.push_back((gx + col) % 256);
            ey.push_back((gy + r) % 128);
            ep.push_back(exp_plot(gx + col, gy + r));
         end
      end
      hx = (n > 0) ? (gx + n - 1) % 256 : gx;
      hy = (n > 0) ? (gy + n - 1) % 128 : gy;

      bus.start  = 1'b1;
      bus.givex  = 8'(gx);
      bus.givey  = 7'(gy);
      bus.size   = SIZE_W'(n);
      bus.colour = 3'(c);
      @(negedge clock);
      if (scramble) scramble_inputs();
      else bus.start = 1'b0;

      for (int i = 0; i < ex.size(); i++) begin
         check("pix_x", bus.x, ex[i]);
         check("pix_y", bus.y, ey[i]);
         check("pix_plot", bus.plot, ep[i]);
         check("pix_busy", bus.busy, 1);
         check("pix_done", bus.done, 0);
         check("pix_colour", bus.colour_out, c);
         if (scramble) scramble_inputs();
         @(negedge clock);
      end

      check("done_pulse", bus.done, 1);
      check("done_busy", bus.busy, 1);
      check("done_plot", bus.plot, 0);
      check("done_colour", bus.colour_out, c);
      bus.start = scramble;
      @(negedge clock);

      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_plot", bus.plot, 0);
      check("idle_hold_x", bus.x, hx);
      check("idle_hold_y", bus.y, hy);
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.givex  = 8'd0;
      bus.givey  = 7'd0;
      bus.size   = '0;
      bus.colour = 3'd0;
      repeat (2) @(negedge clock);
      check("rst_x", bus.x, 0);
      check("rst_y", bus.y, 0);
      check("rst_plot", bus.plot, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_colour", bus.colour_out, 0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_busy", bus.busy, 0);

      // Directed cases.
      run_box(10, 20, 2, 3'b100, 1'b0);
      run_box(5, 5, 0, 7, 1'b0);
      run_box(0, 0, 3, 6, 1'b1);
      run_box(158, 118, 3, 2, 1'b0);
      run_box(250, 125, 4, 5, 1'b0);
      run_box(40, 30, 1, 1, 1'b1);
      run_box(41, 31, 1, 2, 1'b0);

      // Reset on the 4th pixel of a size-4 box.
      bus.start  = 1'b1;
      bus.givex  = 8'd20;
      bus.givey  = 7'd30;
      bus.size   = SIZE_W'(4);
      bus.colour = 3'd3;
      @(negedge clock);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("pre_rst_plot", bus.plot, 1);
         @(negedge clock);
      end
      check("rst4_x", bus.x, 23);
      check("rst4_y", bus.y, 30);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_plot", bus.plot, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_x", bus.x, 0);
      check("abort_y", bus.y, 0);
      check("abort_done", bus.done, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("abort_no_done", bus.done, 0);
         check("abort_idle", bus.busy, 0);
      end
      run_box(20, 30, 4, 3, 1'b0);

      // Randomised boxes, some hugging the screen edges.
      for (int t = 0; t < 30; t++) begin
         int gx;
         int gy;
         if ($urandom_range(0, 1) == 1) begin
            gx = $urandom_range(SCREEN_W - 16, 255);
            gy = $urandom_range(SCREEN_H - 16, 127);
         end else begin
            gx = $urandom_range(0, 255);
            gy = $urandom_range(0, 127);
         end
         run_box(gx, gy, $urandom_range(0, 15), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            bus.start = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
